// File: rtl/g_rgb_lerp.sv
// One colour channel of the gradient mapper: registers the rounded product,
// then adds the floor-shifted product onto the lower key.
module g_rgb_lerp #(
    parameter int unsigned n = 8,
    parameter int unsigned F = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [n-1:0] c0_i,
    input  logic [n-1:0] c1_i,
    input  logic [F-1:0] frac_i,
    output logic [n-1:0] out_o
);
    localparam int unsigned DW   = n + 1;
    localparam int unsigned PW   = n + F + 1;
    localparam int unsigned HALF = 1 << (F - 1);

    logic signed [DW-1:0] d_c;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] p_d;
    logic signed [PW-1:0] p_q;
    logic        [n-1:0]  c0_q;
    logic        [n-1:0]  out_d;
    logic        [n-1:0]  out_q;

    // |d*frac| + HALF stays below 2^(n+F), so PW bits never overflow
    assign d_c    = $signed({1'b0, c1_i}) - $signed({1'b0, c0_i});
    assign prod_c = PW'(d_c) * PW'($signed({1'b0, frac_i}));
    assign p_d    = prod_c + $signed(PW'(HALF));
    assign out_d  = n'($signed({{(F + 1){1'b0}}, c0_q}) + (p_q >>> F));

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            c0_q  <= '0;
            out_q <= '0;
        end else if (en) begin
            p_q   <= p_d;
            c0_q  <= c0_i;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

// File: rtl/g_rgb_gradient.sv
// Luma to RGB false-colour mapper over a writable 17-key palette,
// 3-stage valid/ready pipeline with a global stall.
module g_rgb_gradient #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [m-1:0]   in_y,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [n-1:0]   out_r,
    output logic [n-1:0]   out_g,
    output logic [n-1:0]   out_b,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           wr_en,
    input  logic [4:0]     wr_addr,
    input  logic [3*n-1:0] wr_data
);
    localparam int unsigned F    = m - 4;
    localparam int unsigned KEYS = 17;
    localparam int unsigned CW   = 3 * n;

    logic [CW-1:0] key_q [KEYS];
    logic [4:0]    seg_c;
    logic [CW-1:0] c0_c;
    logic [CW-1:0] c1_c;
    logic          en_c;

    logic [CW-1:0] c0_q;
    logic [CW-1:0] c1_q;
    logic [F-1:0]  frac_q;
    logic          v1_q;
    logic          v2_q;
    logic          out_valid_q;
    logic [CW-1:0] rgb;

    // Reset palette: gray ramp with the top key pinned to full scale
    function automatic logic [CW-1:0] ramp_key(input int unsigned k);
        logic [n-1:0] ch;
        if (k >= 16) ch = '1;
        else         ch = n'(k << (n - 4));
        return {3{ch}};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KEYS; k++) key_q[k] <= ramp_key(k);
        end else begin
            for (int k = 0; k < KEYS; k++)
                if (wr_en && (wr_addr == 5'(k))) key_q[k] <= wr_data;
        end
    end

    // Lookup reads the flops directly, so a same-cycle write is not yet visible
    assign seg_c = {1'b0, in_y[m-1:F]};
    assign c0_c  = key_q[seg_c];
    assign c1_c  = key_q[seg_c + 5'd1];

    assign en_c     = !out_valid_q || out_ready;
    assign in_ready = en_c && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            c0_q        <= '0;
            c1_q        <= '0;
            frac_q      <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en_c) begin
            c0_q        <= c0_c;
            c1_q        <= c1_c;
            frac_q      <= in_y[F-1:0];
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        g_rgb_lerp #(.n(n), .F(F)) u_lerp (
            .clk    (clk),
            .rst    (rst),
            .en     (en_c),
            .c0_i   (c0_q[ch*n +: n]),
            .c1_i   (c1_q[ch*n +: n]),
            .frac_i (frac_q),
            .out_o  (rgb[ch*n +: n])
        );
    end

    assign out_r     = rgb[3*n-1:2*n];
    assign out_g     = rgb[2*n-1:n];
    assign out_b     = rgb[n-1:0];
    assign out_valid = out_valid_q;
endmodule

// File: doc/g_rgb_gradient.md
# g_rgb_gradient

Maps a grayscale luma stream onto a programmable 17-key color gradient and emits RGB pixels. Each key is a color, and output colors are linearly interpolated between adjacent keys. The block sits after the RGB-to-gray converters (or any luma source) and produces false-color, heat-map or tinted video. It has a 3-stage valid/ready pipeline and a register-based palette write port.

## Interface
- m, 8: luma input width; 5 ≤ m ≤ 12
- n, 8: per-channel RGB output width; 4 ≤ n ≤ 10
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_y  in  m  luma sample
- in_valid  in  1  in_y valid
- in_ready  out  1  block accepts in_y this cycle
- out_r, out_g, out_b  out  n each  interpolated color
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts output
- wr_en  in  1  palette write strobe
- wr_addr  in  5  key index 0..16; values 17..31 are ignored
- wr_data  in  3n  {R,G,B}, with R in the MSBs

## Operation
- Palette: 17 keys (K0..K16), each 3×n bits, held in flops.
- Palette reset value is a gray ramp:
  - Kk = k << (n-4) per channel for k < 16
  - K16 = all ones
- Segment and fraction:
  - F = m-4
  - seg = in_y[m-1:F], range 0..15
  - frac = in_y[F-1:0]
- Interpolation, per channel:
  - c0 = K[seg], c1 = K[seg+1]
  - d = c1 − c0, signed (n+1) bits
  - p = d·frac + 2^(F-1), signed (n+F+1) bits
  - out = c0 + (p >>> F), with an arithmetic (floor) shift
- Width rule: the result always lies between c0 and c1 inclusive. It is truncated to n bits, and no saturation is required.
- Stage 1, on accept: capture c0, c1 (looked up combinationally from in_y) and frac for all three channels.
- Stage 2: register the three products p.
- Stage 3: register the final sums, which drive out_r, out_g and out_b.
- Flow control is a global stall:
  - en = !out_valid || out_ready
  - in_ready = en && !rst
  - All stage registers and their valid bits advance only when en is high. Bubbles carry valid = 0.
- Palette write: Kwr_addr ← wr_data at the clock edge when wr_en is high and wr_addr ≤ 16.
- Write/lookup collision: a pixel accepted in the same cycle as a write sees the old key. Pixels accepted on later cycles see the new key. Pixels already in the pipeline are unaffected.
- Writes are accepted in every cycle regardless of stall state.

## Timing
- Latency is 3 cycles: a pixel accepted at edge t appears with out_valid = 1 after edge t+2 when out_ready stays high.
- Throughput is 1 pixel per cycle.
- Stall behavior while out_valid && !out_ready:
  - in_ready = 0
  - All stages hold.
  - out_r, out_g, out_b and out_valid stay stable until the edge where they are accepted.
- Simultaneous out_ready and in_valid while the pipeline is full: the pipeline advances and the new pixel is accepted in the same cycle.
- Reset, including mid-stream:
  - All stage valids, out_valid and out_r/g/b go to 0.
  - The palette returns to the ramp.
  - in_ready = 0 while rst is high and 1 in the first cycle after reset.
  - In-flight pixels are discarded.
- A write concurrent with rst is ignored, because reset has priority.

## Structure
- No shared package is needed. The localparams F = m-4 and KEYS = 17 live in the module.
- Natural sub-module: g_rgb_lerp, a one-channel c0/c1/frac → out two-register datapath.
  - It takes en and is instantiated 3× (R, G, B).
  - The top level owns the palette, the valid pipeline and the handshake.

## Test plan
- Default palette identity, m = n = 8, out_ready high:
  - in_y 0, 128, 136, 255 → gray outputs 0, 128, 136, 254 respectively, each 3 cycles after accept.
- Red-to-blue segment:
  - Write K4 = {255,0,0} and K5 = {0,0,255}, then in_y = 72.
  - Expected out = {128, 0, 128}; in_y = 64 → {255, 0, 0}.
- Backpressure:
  - Stream in_y = 0..20 continuously while toggling out_ready in a 3-cycle-low/2-cycle-high pattern.
  - Expected: the output sequence is exact and in order, with no drops or duplicates, and outputs are stable while stalled.
- Write collision:
  - Accept in_y = 64 in the same cycle as writing K4 = {0,255,0} → that pixel outputs {64,64,64}.
  - The next pixel with in_y = 64 → {0,255,0}.
  - A write with wr_addr = 20 leaves the palette unchanged.
- Reset mid-stream:
  - Assert rst for 1 cycle with 3 pixels in flight and K4 modified.
  - Expected: out_valid = 0 on the next cycle, no stale pixel is ever emitted, and in_y = 64 then yields {64,64,64}.
